// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_STALL_W  = 16;

  // Requester-select encoding, also used to remember the last winner.
  typedef logic req_sel_t;
  localparam req_sel_t REQ_A = 1'b0;
  localparam req_sel_t REQ_B = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of both requester handshakes, the register-file write port and status outputs.
// Latency: n/a (wiring only).
// Backpressure: requester side sees req_ready_x; the write port itself has no backpressure.
// Ports: master = requester/regfile side, slave = arbiter side.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int STALL_W  = RF_STALL_W
) ();

  logic                req_valid_a;
  logic [ADDR_W-1:0]   req_addr_a;
  logic [DATA_W-1:0]   req_data_a;
  logic                req_ready_a;

  logic                req_valid_b;
  logic [ADDR_W-1:0]   req_addr_b;
  logic [DATA_W-1:0]   req_data_b;
  logic                req_ready_b;

  logic                write_enable;
  logic [ADDR_W-1:0]   write_address;
  logic [DATA_W-1:0]   write_data_in;

  logic [NUM_REGS-1:0] pending_mask;
  logic [STALL_W-1:0]  stall_count;

  modport master (
    output req_valid_a, req_addr_a, req_data_a,
    output req_valid_b, req_addr_b, req_data_b,
    input  req_ready_a, req_ready_b,
    input  write_enable, write_address, write_data_in,
    input  pending_mask, stall_count
  );

  modport slave (
    input  req_valid_a, req_addr_a, req_data_a,
    input  req_valid_b, req_addr_b, req_data_b,
    output req_ready_a, req_ready_b,
    output write_enable, write_address, write_data_in,
    output pending_mask, stall_count
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter over buffer occupancy, one-hot grant.
// Latency: combinational.
// Backpressure: none; a grant only appears for an asserted request.
// Ports: req_a/req_b request bits, last_grant previous winner, grant_a/grant_b one-hot grant.
module regfile_write_arbiter_rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic     req_a,
  input  logic     req_b,
  input  req_sel_t last_grant,
  output logic     grant_a,
  output logic     grant_b
);

  // On a conflict the requester that did not win last time goes first.
  assign grant_a = req_a && (!req_b || (last_grant == REQ_B));
  assign grant_b = req_b && (!req_a || (last_grant == REQ_A));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between A (ALU) and B (load) writeback.
// Latency: transfer at edge N -> write_enable high after edge N+1.
// Backpressure: one-entry buffer per requester; req_ready_x = buffer empty or draining this cycle.
// Ports: clock/reset, bus (slave modport): requester handshakes, write port, pending_mask, stall_count.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int DISCARD_ZERO = 1,
  parameter int STALL_W      = RF_STALL_W
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);

  localparam bit DISCARD = (DISCARD_ZERO != 0);
  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Holding buffers
  logic              occ_a_q, occ_a_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic              occ_b_q, occ_b_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;

  // Output stage, arbitration history, stall counter
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  req_sel_t          last_grant_q, last_grant_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic grant_a, grant_b;
  logic ready_a, ready_b;
  logic xfer_a, xfer_b;
  logic keep_a, keep_b;
  logic stall_event;
  logic [NUM_REGS-1:0] pending;

  regfile_write_arbiter_rr_arbiter2 u_arb (
    .req_a      (occ_a_q),
    .req_b      (occ_b_q),
    .last_grant (last_grant_q),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  // A buffer being drained this cycle can be refilled in the same cycle.
  assign ready_a = !occ_a_q || grant_a;
  assign ready_b = !occ_b_q || grant_b;
  assign xfer_a  = bus.req_valid_a && ready_a;
  assign xfer_b  = bus.req_valid_b && ready_b;

  // Writes to r0 complete the handshake but are never buffered.
  assign keep_a = xfer_a && !(DISCARD && (bus.req_addr_a == '0));
  assign keep_b = xfer_b && !(DISCARD && (bus.req_addr_b == '0));

  assign stall_event = (bus.req_valid_a && !ready_a) || (bus.req_valid_b && !ready_b);

  always_comb begin
    occ_a_d      = occ_a_q;
    addr_a_d     = addr_a_q;
    data_a_d     = data_a_q;
    occ_b_d      = occ_b_q;
    addr_b_d     = addr_b_q;
    data_b_d     = data_b_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;

    // Drain first so a same-cycle refill overrides the clear.
    if (grant_a) occ_a_d = 1'b0;
    if (grant_b) occ_b_d = 1'b0;
    if (keep_a) begin
      occ_a_d  = 1'b1;
      addr_a_d = bus.req_addr_a;
      data_a_d = bus.req_data_a;
    end
    if (keep_b) begin
      occ_b_d  = 1'b1;
      addr_b_d = bus.req_addr_b;
      data_b_d = bus.req_data_b;
    end

    if (grant_a) begin
      we_d         = 1'b1;
      waddr_d      = addr_a_q;
      wdata_d      = data_a_q;
      last_grant_d = REQ_A;
    end else if (grant_b) begin
      we_d         = 1'b1;
      waddr_d      = addr_b_q;
      wdata_d      = data_b_q;
      last_grant_d = REQ_B;
    end

    if (stall_event && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_a_q      <= 1'b0;
      addr_a_q     <= '0;
      data_a_q     <= '0;
      occ_b_q      <= 1'b0;
      addr_b_q     <= '0;
      data_b_q     <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_grant_q <= REQ_B;
      stall_q      <= '0;
    end else begin
      occ_a_q      <= occ_a_d;
      addr_a_q     <= addr_a_d;
      data_a_q     <= data_a_d;
      occ_b_q      <= occ_b_d;
      addr_b_q     <= addr_b_d;
      data_b_q     <= data_b_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
    end
  end

  // Any write not yet committed to the register file, for hazard detection.
  always_comb begin
    pending = '0;
    if (occ_a_q) pending = pending | (ONE << addr_a_q);
    if (occ_b_q) pending = pending | (ONE << addr_b_q);
    if (we_q)    pending = pending | (ONE << waddr_q);
  end

  assign bus.req_ready_a   = ready_a;
  assign bus.req_ready_b   = ready_b;
  assign bus.write_enable  = we_q;
  assign bus.write_address = waddr_q;
  assign bus.write_data_in = wdata_q;
  assign bus.pending_mask  = pending;
  assign bus.stall_count   = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (STALL_W=4 so saturation is reachable).
// Latency: n/a.
// Backpressure: driver holds a request until the DUT shows ready.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  wr_t  exp_a[$];
  wr_t  exp_b[$];
  wr_t  log_q[$];
  logic [31:0] rf [32];
  wr_t  mon_w;

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .STALL_W(4)) bus ();

  regfile_write_arbiter #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .DISCARD_ZERO(1), .STALL_W(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Register-file model commits on negedge; every write is scoreboarded
  // against the head of the issuing requester's queue.
  always @(negedge clock) begin
    if (bus.write_enable) begin
      mon_w.a = bus.write_address;
      mon_w.d = bus.write_data_in;
      log_q.push_back(mon_w);
      rf[mon_w.a] = mon_w.d;
      total++;
      if (exp_a.size() > 0 && exp_a[0] == mon_w) begin
        void'(exp_a.pop_front());
      end else if (exp_b.size() > 0 && exp_b[0] == mon_w) begin
        void'(exp_b.pop_front());
      end else begin
        bad++;
        $display("FAIL sb_write: got addr=%0d data=%h, expected head A=%0d B=%0d entries",
                 mon_w.a, mon_w.d, exp_a.size(), exp_b.size());
      end
    end
  end

  // Present one cycle of requests (called just after a negedge); returns the
  // readies seen before the edge and returns at the following negedge.
  task automatic drive(input logic va, input logic [4:0] aa, input logic [31:0] da,
                       input logic vb, input logic [4:0] ab, input logic [31:0] db,
                       output logic ra, output logic rb);
    wr_t w;
    bus.req_valid_a = va; bus.req_addr_a = aa; bus.req_data_a = da;
    bus.req_valid_b = vb; bus.req_addr_b = ab; bus.req_data_b = db;
    #1;
    ra = bus.req_ready_a;
    rb = bus.req_ready_b;
    if (va && ra && aa != 5'd0) begin w.a = aa; w.d = da; exp_a.push_back(w); end
    if (vb && rb && ab != 5'd0) begin w.a = ab; w.d = db; exp_b.push_back(w); end
    @(posedge clock);
    #1;
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    exp_a.delete();
    exp_b.delete();
    log_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic ra, rb;
    #2;
    total++;
    if ({bus.write_enable, bus.write_address, bus.write_data_in} !== 38'd0) begin
      bad++;
      $display("FAIL reset_port: got we=%b addr=%0d data=%h, expected all 0",
               bus.write_enable, bus.write_address, bus.write_data_in);
    end
    total++;
    if (bus.pending_mask !== 32'd0 || bus.stall_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_status: got mask=%h stall=%0d, expected 0/0", bus.pending_mask, bus.stall_count);
    end
    total++;
    if (bus.req_ready_a !== 1'b1 || bus.req_ready_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b%b, expected 11", bus.req_ready_a, bus.req_ready_b);
    end
    @(negedge clock);
    reset = 1'b0;
    // Leave a write to r3 sitting in A's buffer, then reset over it.
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, ra, rb);
    total++;
    if (bus.pending_mask !== 32'h8) begin
      bad++;
      $display("FAIL midrst_pending_before: got %h, expected 00000008", bus.pending_mask);
    end
    reset = 1'b1;
    #1;
    exp_a.delete();
    total++;
    if (bus.pending_mask !== 32'd0 || bus.write_enable !== 1'b0 || bus.write_address !== 5'd0) begin
      bad++;
      $display("FAIL midrst_clear: got mask=%h we=%b addr=%0d, expected 0/0/0",
               bus.pending_mask, bus.write_enable, bus.write_address);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (bus.write_enable !== 1'b0) begin
        bad++;
        $display("FAIL midrst_no_we: cycle %0d got we=%b, expected 0", i, bus.write_enable);
      end
    end
  endtask

  task automatic test_single();
    logic ra, rb;
    apply_reset();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ra, rb);
    total++;
    if (bus.pending_mask !== 32'h20 || bus.write_enable !== 1'b0) begin
      bad++;
      $display("FAIL single_n: got mask=%h we=%b, expected 00000020/0", bus.pending_mask, bus.write_enable);
    end
    @(negedge clock);
    total++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 5'd5 || bus.write_data_in !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_n1: got we=%b addr=%0d data=%h, expected 1/5/deadbeef",
               bus.write_enable, bus.write_address, bus.write_data_in);
    end
    @(negedge clock);
    total++;
    if (bus.write_enable !== 1'b0 || bus.pending_mask !== 32'd0) begin
      bad++;
      $display("FAIL single_n2: got we=%b mask=%h, expected 0/0", bus.write_enable, bus.pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    logic ra, rb, va, vb;
    logic [4:0] aa [3];
    logic [4:0] ab [3];
    logic [4:0] order [6];
    logic era [5];
    logic erb [5];
    logic [3:0] est [5];
    int ia, ib;
    aa = '{5'd1, 5'd2, 5'd3};
    ab = '{5'd9, 5'd10, 5'd11};
    order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    era = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    erb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    est = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
    ia = 0;
    ib = 0;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      va = (ia < 3);
      vb = (ib < 3);
      drive(va, va ? aa[ia] : 5'd0, 32'hA000 + ia, vb, vb ? ab[ib] : 5'd0, 32'hB000 + ib, ra, rb);
      if (va) begin
        total++;
        if (ra !== era[c]) begin
          bad++;
          $display("FAIL stream_ready_a: cycle %0d got %b, expected %b", c, ra, era[c]);
        end
      end
      if (vb) begin
        total++;
        if (rb !== erb[c]) begin
          bad++;
          $display("FAIL stream_ready_b: cycle %0d got %b, expected %b", c, rb, erb[c]);
        end
      end
      total++;
      if (bus.stall_count !== est[c]) begin
        bad++;
        $display("FAIL stream_stall: cycle %0d got %0d, expected %0d", c, bus.stall_count, est[c]);
      end
      if (va && ra) ia++;
      if (vb && rb) ib++;
    end
    repeat (4) @(negedge clock);
    total++;
    if (log_q.size() != 6) begin
      bad++;
      $display("FAIL stream_count: got %0d writes, expected 6", log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_q[i].a !== order[i]) begin
          bad++;
          $display("FAIL stream_order: slot %0d got addr %0d, expected %0d", i, log_q[i].a, order[i]);
        end
      end
    end
  endtask

  task automatic test_same_addr();
    logic ra, rb;
    apply_reset();
    drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, ra, rb);
    repeat (3) @(negedge clock);
    total++;
    if (log_q.size() != 2 || log_q[0].d !== 32'h11 || log_q[1].d !== 32'h22) begin
      bad++;
      $display("FAIL same_addr_order: got %0d writes first=%h, expected 2 writes 11 then 22",
               log_q.size(), (log_q.size() > 0) ? log_q[0].d : 32'hx);
    end
    total++;
    if (rf[7] !== 32'h22) begin
      bad++;
      $display("FAIL same_addr_final: got r7=%h, expected 00000022", rf[7]);
    end
  endtask

  task automatic test_zero_reg();
    logic ra, rb;
    apply_reset();
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, ra, rb);
    total++;
    if (ra !== 1'b1) begin
      bad++;
      $display("FAIL zero_ready: got %b, expected 1", ra);
    end
    total++;
    if (bus.pending_mask !== 32'd0) begin
      bad++;
      $display("FAIL zero_pending: got %h, expected 0", bus.pending_mask);
    end
    repeat (2) @(negedge clock);
    total++;
    if (log_q.size() != 0) begin
      bad++;
      $display("FAIL zero_no_write: got %0d writes, expected 0", log_q.size());
    end
  endtask

  task automatic test_stall_saturation();
    logic ra, rb;
    logic [4:0] aa, ab;
    logic [31:0] da, db;
    int exp_cnt;
    apply_reset();
    aa = 5'($urandom_range(1, 31)); da = $urandom;
    ab = 5'($urandom_range(1, 31)); db = $urandom;
    for (int c = 0; c < 25; c++) begin
      drive(1'b1, aa, da, 1'b1, ab, db, ra, rb);
      exp_cnt = (c < 15) ? c : 15;
      total++;
      if (bus.stall_count !== 4'(exp_cnt)) begin
        bad++;
        $display("FAIL sat_count: cycle %0d got %0d, expected %0d", c, bus.stall_count, exp_cnt);
      end
      if (c > 0) begin
        total++;
        if ((ra ^ rb) !== 1'b1) begin
          bad++;
          $display("FAIL sat_alternate: cycle %0d got ready %b%b, expected exactly one", c, ra, rb);
        end
      end
      if (ra) begin aa = 5'($urandom_range(1, 31)); da = $urandom; end
      if (rb) begin ab = 5'($urandom_range(1, 31)); db = $urandom; end
    end
    repeat (4) @(negedge clock);
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL sat_drain: got %0d/%0d outstanding, expected 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req_valid_a = 1'b0; bus.req_addr_a = '0; bus.req_data_a = '0;
    bus.req_valid_b = 1'b0; bus.req_addr_b = '0; bus.req_data_b = '0;
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_same_addr();
    test_zero_reg();
    test_stall_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
